// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   - key kinds and the key-code constants for the non-digit keys
//   - frame-result encoding (NONE / SINGLE / MULTI) plus the code of a single press
//   - key_map(): 16-entry lookup from code = row*4+col to key kind and digit value
package keypad_pkg;

    typedef enum logic [2:0] {
        KEY_IGNORED = 3'd0,
        KEY_DIGIT   = 3'd1,
        KEY_START   = 3'd2,
        KEY_CLEAR   = 3'd3,
        KEY_CONFIRM = 3'd4
    } key_kind_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_cls_e;

    typedef struct packed {
        frame_cls_e cls;
        logic [3:0] code;
    } frame_t;

    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] digit;
    } key_info_t;

    localparam frame_t     FRAME_NONE   = '{cls: FR_NONE, code: 4'd0};
    localparam logic [3:0] CODE_START   = 4'd3;
    localparam logic [3:0] CODE_CLEAR   = 4'd7;
    localparam logic [3:0] CODE_CONFIRM = 4'd11;

    // Row 3 holds only the 0 key; its other three positions are ignored.
    function automatic key_info_t key_map(input logic [3:0] code);
        key_info_t info;
        info.kind  = KEY_IGNORED;
        info.digit = 4'd0;
        case (code)
            4'd0:         begin info.kind = KEY_DIGIT;   info.digit = 4'd1; end
            4'd1:         begin info.kind = KEY_DIGIT;   info.digit = 4'd2; end
            4'd2:         begin info.kind = KEY_DIGIT;   info.digit = 4'd3; end
            CODE_START:   begin info.kind = KEY_START;   info.digit = 4'd0; end
            4'd4:         begin info.kind = KEY_DIGIT;   info.digit = 4'd4; end
            4'd5:         begin info.kind = KEY_DIGIT;   info.digit = 4'd5; end
            4'd6:         begin info.kind = KEY_DIGIT;   info.digit = 4'd6; end
            CODE_CLEAR:   begin info.kind = KEY_CLEAR;   info.digit = 4'd0; end
            4'd8:         begin info.kind = KEY_DIGIT;   info.digit = 4'd7; end
            4'd9:         begin info.kind = KEY_DIGIT;   info.digit = 4'd8; end
            4'd10:        begin info.kind = KEY_DIGIT;   info.digit = 4'd9; end
            CODE_CONFIRM: begin info.kind = KEY_CONFIRM; info.digit = 4'd0; end
            4'd13:        begin info.kind = KEY_DIGIT;   info.digit = 4'd0; end
            default:      begin info.kind = KEY_IGNORED; info.digit = 4'd0; end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a new key state after DEBOUNCE_CNT identical frames.
//   clk, rst_n   : clock, async active-low reset
//   frame_valid  : one-cycle strobe, frame_in holds a completed frame result
//   frame_in     : frame result, already reduced to NONE or SINGLE(usable key)
//   accepted     : registered accepted state
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   frame_valid,
    input  frame_t frame_in,
    output frame_t accepted
);

    localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    frame_t        cand_r, cand_nxt;
    frame_t        acc_r, acc_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;

    // Candidate tracking and acceptance, evaluated once per completed frame.
    always_comb begin
        cand_nxt = cand_r;
        cnt_nxt  = cnt_r;
        acc_nxt  = acc_r;
        if (frame_valid) begin
            if (frame_in == cand_r) begin
                if (cnt_r != CNT_MAX) begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt = cnt_r;
                end
            end else begin
                cand_nxt = frame_in;
                cnt_nxt  = CNT_ONE;
            end
            if (cnt_nxt == CNT_MAX) begin
                acc_nxt = cand_nxt;
            end else begin
                acc_nxt = acc_r;
            end
        end else begin
            acc_nxt = acc_r;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= FRAME_NONE;
            cnt_r  <= '0;
            acc_r  <= FRAME_NONE;
        end else begin
            cand_r <= cand_nxt;
            cnt_r  <= cnt_nxt;
            acc_r  <= acc_nxt;
        end
    end

    assign accepted = acc_r;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces and decodes keys.
//   clk, rst_n      : clock, async active-low reset
//   row_n[3:0]      : rows (pulled up, low = pressed on driven column), async
//   col_n[3:0]      : column drive, one bit low at a time
//   keydown_*       : level outputs, at most one high
//   num[3:0]        : last accepted digit
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       keydown_num,
    output logic       keydown_start,
    output logic       keydown_clear,
    output logic       keydown_confirm,
    output logic [3:0] num
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta_r, row_sync_r;
    logic [DW-1:0] div_r;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_n_r;
    logic [3:0]    samp_r [4];
    logic          scan_tick_s, frame_valid_s;
    logic [4:0]    n_press_s;
    logic [3:0]    hit_code_s;
    key_info_t     hit_info_s, acc_info_s;
    frame_t        frame_raw_s, frame_s, acc_s;
    logic          kd_num_r, kd_start_r, kd_clear_r, kd_confirm_r;
    logic          kd_num_nxt, kd_start_nxt, kd_clear_nxt, kd_confirm_nxt;
    logic [3:0]    shown_code_r, shown_code_nxt, num_r, num_nxt;
    logic          showing_s;

    // Two-flop row synchronizer; idles high like the pulled-up rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row_n;
            row_sync_r <= row_meta_r;
        end
    end

    assign scan_tick_s   = (div_r == DIV_LAST);
    assign frame_valid_s = scan_tick_s && (col_idx_r == 2'd3);

    // Divider, column rotation and per-column row capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= '0;
            col_idx_r <= 2'd0;
            col_n_r   <= 4'b1110;
            for (int i = 0; i < 4; i++) begin
                samp_r[i] <= 4'd0;
            end
        end else if (scan_tick_s) begin
            div_r             <= '0;
            col_idx_r         <= col_idx_r + 2'd1;
            col_n_r           <= {col_n_r[2:0], col_n_r[3]};
            samp_r[col_idx_r] <= ~row_sync_r;
        end else begin
            div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // Frame classification; column 3 is taken live since the frame closes on its sample.
    always_comb begin
        n_press_s  = 5'd0;
        hit_code_s = 4'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if ((c == 3) ? ~row_sync_r[r] : samp_r[c][r]) begin
                    n_press_s  = n_press_s + 5'd1;
                    hit_code_s = 4'(r * 4 + c);
                end
            end
        end
        hit_info_s = key_map(hit_code_s);
        if (n_press_s == 5'd0) begin
            frame_raw_s = FRAME_NONE;
        end else if (n_press_s == 5'd1) begin
            frame_raw_s = '{cls: FR_SINGLE, code: hit_code_s};
        end else begin
            frame_raw_s = '{cls: FR_MULTI, code: 4'd0};
        end
        // Chords and ignored keys count as "nothing pressed" for debouncing.
        if (frame_raw_s.cls == FR_SINGLE && hit_info_s.kind != KEY_IGNORED) begin
            frame_s = frame_raw_s;
        end else begin
            frame_s = FRAME_NONE;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid_s),
        .frame_in    (frame_s),
        .accepted    (acc_s)
    );

    assign acc_info_s = key_map(acc_s.code);
    assign showing_s  = kd_num_r | kd_start_r | kd_clear_r | kd_confirm_r;

    // Output decode: a key shown must be dropped for a cycle before a different one appears.
    always_comb begin
        kd_num_nxt     = kd_num_r;
        kd_start_nxt   = kd_start_r;
        kd_clear_nxt   = kd_clear_r;
        kd_confirm_nxt = kd_confirm_r;
        shown_code_nxt = shown_code_r;
        num_nxt        = num_r;
        if (showing_s && (acc_s.cls != FR_SINGLE || acc_s.code != shown_code_r)) begin
            kd_num_nxt     = 1'b0;
            kd_start_nxt   = 1'b0;
            kd_clear_nxt   = 1'b0;
            kd_confirm_nxt = 1'b0;
        end else if (!showing_s && acc_s.cls == FR_SINGLE) begin
            shown_code_nxt = acc_s.code;
            case (acc_info_s.kind)
                KEY_DIGIT: begin
                    kd_num_nxt = 1'b1;
                    num_nxt    = acc_info_s.digit;
                end
                KEY_START:   kd_start_nxt   = 1'b1;
                KEY_CLEAR:   kd_clear_nxt   = 1'b1;
                KEY_CONFIRM: kd_confirm_nxt = 1'b1;
                default:     kd_num_nxt     = 1'b0;
            endcase
        end else begin
            shown_code_nxt = shown_code_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kd_num_r     <= 1'b0;
            kd_start_r   <= 1'b0;
            kd_clear_r   <= 1'b0;
            kd_confirm_r <= 1'b0;
            shown_code_r <= 4'd0;
            num_r        <= 4'd0;
        end else begin
            kd_num_r     <= kd_num_nxt;
            kd_start_r   <= kd_start_nxt;
            kd_clear_r   <= kd_clear_nxt;
            kd_confirm_r <= kd_confirm_nxt;
            shown_code_r <= shown_code_nxt;
            num_r        <= num_nxt;
        end
    end

    assign col_n           = col_n_r;
    assign keydown_num     = kd_num_r;
    assign keydown_start   = kd_start_r;
    assign keydown_clear   = kd_clear_r;
    assign keydown_confirm = kd_confirm_r;
    assign num             = num_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the scanner, a behavioural
// reference checked every cycle, directed scenarios with literal expectations
// and a randomized key/bounce/reset phase.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int BOUND = (DEB + 1) * 4 * DIV + 4;   // 68

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'd0;
    logic [3:0]  row_n, col_n, num;
    logic        keydown_num, keydown_start, keydown_clear, keydown_confirm;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .row_n           (row_n),
        .col_n           (col_n),
        .keydown_num     (keydown_num),
        .keydown_start   (keydown_start),
        .keydown_clear   (keydown_clear),
        .keydown_confirm (keydown_confirm),
        .num             (num)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] cols);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4+c] && !cols[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    assign row_n = keypad_rows(keys, col_n);

    logic [3:0] row_at_edge = 4'hF;
    logic       rst_at_edge = 1'b0;
    always @(posedge clk) begin
        row_at_edge <= row_n;
        rst_at_edge <= rst_n;
    end

    // ---------------- behavioural reference ----------------
    // key meaning: 0..9 digit, 10 start, 11 clear, 12 confirm, -1 ignored
    int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -1, -1};
    int m_tick, m_cand, m_cnt, m_acc, m_shown, m_num;
    logic [3:0] m_h1, m_h2;
    logic [3:0] m_rows [4];

    task model_reset();
        m_tick = 0; m_cand = -1; m_cnt = 0; m_acc = -1; m_shown = -1; m_num = 0;
        m_h1 = 4'hF; m_h2 = 4'hF;
        for (int i = 0; i < 4; i++) m_rows[i] = 4'hF;
    endtask

    task model_edge(input logic [3:0] row);
        logic [3:0] synced;
        int col, npress, code, eff;
        synced = m_h2; m_h2 = m_h1; m_h1 = row;
        // outputs follow the accepted state one clock late, with a blank between keys
        if (m_shown != -1 && m_acc != m_shown) m_shown = -1;
        else if (m_shown == -1 && m_acc != -1) begin
            m_shown = m_acc;
            if (kmap[m_acc] >= 0 && kmap[m_acc] <= 9) m_num = kmap[m_acc];
        end
        col = (m_tick / DIV) % 4;
        if (m_tick % DIV == DIV - 1) begin
            m_rows[col] = synced;
            if (col == 3) begin
                npress = 0; code = 0;
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        if (!m_rows[c][r]) begin npress++; code = r * 4 + c; end
                eff = (npress == 1 && kmap[code] != -1) ? code : -1;
                if (eff == m_cand) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
                else begin m_cand = eff; m_cnt = 1; end
                if (m_cnt == DEB) m_acc = m_cand;
            end
        end
        m_tick++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Per-cycle compare against the reference.
    initial begin
        logic [3:0] exp_kd, act_kd, exp_col;
        int kind;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_at_edge || !rst_n) model_reset();
            else model_edge(row_at_edge);
            kind = (m_shown == -1) ? -1 : kmap[m_shown];
            exp_kd = {kind == 12, kind == 11, kind == 10, (kind >= 0 && kind <= 9)};
            exp_col = 4'hF & ~(4'b0001 << ((m_tick / DIV) % 4));
            act_kd = {keydown_confirm, keydown_clear, keydown_start, keydown_num};
            n_cmp++;
            if (act_kd !== exp_kd || col_n !== exp_col || num !== 4'(m_num)) begin
                n_bad++;
                $display("FAIL cycle@%0t: got col_n=%b kd=%b num=%0d, want col_n=%b kd=%b num=%0d",
                         $time, col_n, act_kd, num, exp_col, exp_kd, m_num);
            end
            check("onehot", int'($countones(act_kd) <= 1), 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic kd_sel(input int which);
        case (which)
            0: return keydown_num;
            1: return keydown_start;
            2: return keydown_clear;
            default: return keydown_confirm;
        endcase
    endfunction

    task automatic wait_kd(input int which, input logic lvl, input int bound, output int n);
        n = 0;
        while (n <= bound) begin
            @(negedge clk);
            n++;
            if (kd_sel(which) == lvl) break;
        end
    endtask

    function automatic logic [15:0] key(input int code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    initial begin
        int n, rises, low_cnt, sel, dur, mode;
        logic saw, prev, fell, clr;

        // reset state
        clocks(2);
        check("reset_col_n", int'(col_n), 4'b1110);
        check("reset_kd", int'({keydown_num, keydown_start, keydown_clear, keydown_confirm}), 0);
        check("reset_num", int'(num), 0);
        rst_n = 1'b1;
        clocks(20);

        // digit 7 press and release
        keys = key(8);
        wait_kd(0, 1'b1, BOUND + 2, n);
        check_range("press7_latency", n, 1, BOUND);
        check("press7_num", int'(num), 7);
        clocks(5);
        keys = 16'd0;
        wait_kd(0, 1'b0, BOUND + 2, n);
        check_range("release7_latency", n, 1, BOUND);
        check("release7_num_held", int'(num), 7);
        clocks(40);

        // start bouncing for 40 clocks, then held
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            keys = (((i / 10) % 2) == 0) ? key(3) : 16'd0;
            clocks(1);
            if (keydown_start) saw = 1'b1;
        end
        check("bounce_no_edge", int'(saw), 0);
        keys = key(3);
        rises = 0; prev = keydown_start;
        for (int i = 0; i < 100; i++) begin
            clocks(1);
            if (keydown_start && !prev) rises++;
            prev = keydown_start;
        end
        check("bounce_single_rise", rises, 1);
        keys = 16'd0;
        wait_kd(1, 1'b0, BOUND + 2, n);
        clocks(30);

        // chord 1+2 blocked, then 1 alone accepted
        keys = key(0) | key(1);
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            clocks(1);
            if (keydown_num | keydown_start | keydown_clear | keydown_confirm) saw = 1'b1;
        end
        check("chord_silent", int'(saw), 0);
        keys = key(0);
        wait_kd(0, 1'b1, BOUND + 2, n);
        check_range("chord_release_latency", n, 1, BOUND);
        check("chord_num", int'(num), 1);
        keys = 16'd0;
        wait_kd(0, 1'b0, BOUND + 2, n);
        clocks(30);

        // confirm directly to clear
        keys = key(11);
        wait_kd(3, 1'b1, BOUND + 2, n);
        check_range("confirm_latency", n, 1, BOUND);
        clocks(3);
        keys = key(7);
        fell = 1'b0; clr = 1'b0; low_cnt = 0;
        for (int i = 0; i < 150 && !clr; i++) begin
            @(negedge clk);
            if (!keydown_confirm) fell = 1'b1;
            if (keydown_clear) clr = 1'b1;
            else if (fell && !keydown_num && !keydown_start) low_cnt++;
        end
        check("switch_confirm_fell", int'(fell), 1);
        check("switch_clear_rose", int'(clr), 1);
        check_range("switch_gap_cycles", low_cnt, 1, 1000);
        keys = 16'd0;
        wait_kd(2, 1'b0, BOUND + 2, n);
        clocks(30);

        // reset while 5 is accepted and held
        keys = key(5);
        wait_kd(0, 1'b1, BOUND + 2, n);
        check("five_num", int'(num), 5);
        clocks(1);
        rst_n = 1'b0;
        #1;
        check("midrst_kd", int'({keydown_num, keydown_start, keydown_clear, keydown_confirm}), 0);
        check("midrst_col_n", int'(col_n), 4'b1110);
        check("midrst_num", int'(num), 0);
        clocks(3);
        rst_n = 1'b1;
        wait_kd(0, 1'b1, BOUND + 2, n);
        check_range("rerise_latency", n, DEB * 4 * DIV, BOUND);
        check("rerise_num", int'(num), 5);
        keys = 16'd0;
        wait_kd(0, 1'b0, BOUND + 2, n);
        clocks(10);

        // "*" alone is ignored
        keys = key(12);
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            clocks(1);
            if (keydown_num | keydown_start | keydown_clear | keydown_confirm) saw = 1'b1;
        end
        check("star_silent", int'(saw), 0);
        check("star_num_kept", int'(num), 5);
        keys = 16'd0;
        clocks(20);

        // randomized keys, chords, bounces and reset pulses
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 9);
            dur  = $urandom_range(4, 80);
            if (mode == 9) begin
                rst_n = 1'b0;
                clocks($urandom_range(1, 3));
                rst_n = 1'b1;
            end else begin
                sel = $urandom_range(0, 15);
                if (mode <= 1) keys = 16'd0;
                else if (mode <= 6) keys = key(sel);
                else keys = key(sel) | key($urandom_range(0, 15));
                for (int i = 0; i < dur; i++) begin
                    if (i < 12 && $urandom_range(0, 3) == 0) begin
                        keys = keys ^ key(sel);
                    end
                    clocks(1);
                end
            end
        end
        keys = 16'd0;
        clocks(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, 50000, clocks per column step; legal range >= 2.
REQ-002 DEBOUNCE_CNT, 4, consecutive identical frames required to accept a new key state; legal range >= 1.
REQ-003 clk  input  1  high-frequency system clock, the same clock the countdown logic uses; the block has one clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 row_n  input  4  keypad rows, pulled up, low = pressed on the driven column; asynchronous to clk.
REQ-006 col_n  output  4  column drive, exactly one bit low at a time.
REQ-007 keydown_num  output  1  level, high while an accepted digit key is held.
REQ-008 keydown_start  output  1  level, high while an accepted start key is held.
REQ-009 keydown_clear  output  1  level, high while an accepted clear key is held.
REQ-010 keydown_confirm  output  1  level, high while an accepted confirm key is held.
REQ-011 num  output  4  last accepted digit, 0-9.

Function
REQ-012 Key map is (row, col): row0 = 1 2 3 start; row1 = 4 5 6 clear; row2 = 7 8 9 confirm; row3 = ignored 0 ignored ignored.
REQ-013 row_n shall pass through a 2-flop synchronizer before any use.
REQ-014 A divider shall count 0..SCAN_DIV-1; on the terminal count the block samples the synchronized rows for the current column, then advances col_n 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 A frame is four column samples, from column 0 through column 3; each frame is evaluated at the column-3 sample.
REQ-016 Frame result classes: NONE (no row low), SINGLE(code), where code = row*4+col (exactly one press), or MULTI (two or more presses, ignored keys included).
REQ-017 MULTI and SINGLE of an ignored key shall both be treated as NONE for acceptance.
REQ-018 If the frame result equals the candidate, the stable count increments, saturating at DEBOUNCE_CNT; otherwise the candidate becomes the frame result and the count becomes 1.
REQ-019 When the count reaches DEBOUNCE_CNT, the accepted state becomes the candidate.
REQ-020 Outputs are registered from the accepted state and update in the clock after acceptance.
REQ-021 At most one keydown_* output shall be high in any cycle.
REQ-022 Changing directly from one accepted key to another shall drive all keydown_* low for at least one clock before the new key goes high, so that the downstream edge detector sees a fresh rising edge.
REQ-023 num updates only when a digit is accepted and holds its value after release or after a non-digit key.
REQ-024 Latency from a stable press to the output edge shall be at most (DEBOUNCE_CNT+1)*4*SCAN_DIV+4 clocks; release latency has the same bound.
REQ-025 A bounce shorter than one frame shall never produce an output edge.

Reset
REQ-026 While rst_n is low: divider 0, col_n = 1110, candidate NONE, count 0, accepted NONE, all keydown_* 0, num 0, synchronizer flops 1.
REQ-027 Asserting reset mid-scan or mid-press shall clear all state immediately; after release, scanning restarts at column 0.
REQ-028 A key held across reset release shall be re-debounced from zero.

Structure
REQ-029 Package keypad_pkg shall hold the key-code constants (digit, start, clear, confirm, ignored), the frame-result encoding (NONE/SINGLE/MULTI) and the 16-entry key-map function.
REQ-030 Debounce shall be a sub-module keypad_debounce, parameterized by DEBOUNCE_CNT, that takes a frame result plus a valid strobe and produces the accepted state.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 clocks)
REQ-031 Press key "7" (row2, col0) continuously -> keydown_num rises within 68 clocks with num=7; release -> keydown_num falls within 68 clocks and num stays 7.
REQ-032 Press start, toggling row_n every 10 clocks for 40 clocks, then hold -> no keydown_start edge during the bounce, one rising edge after the hold.
REQ-033 Hold "1" and "2" simultaneously -> all keydown_* stay 0; release "2" -> keydown_num rises with num=1.
REQ-034 Hold confirm, then switch directly to clear -> keydown_confirm falls, at least one all-low cycle, then keydown_clear rises.
REQ-035 Assert rst_n low for 3 clocks while "5" is accepted -> outputs 0 and col_n=1110 immediately; with "5" still held, keydown_num re-rises only after at least 3 full frames.
REQ-036 Hold "*" alone -> all keydown_* remain 0 and num is unchanged.
